alu_shift_seq: RTL and testbench
================================

// Module: alu_shift_seq
// PURPOSE
//   Parametrised, multi-cycle shift/rotate unit for the ALU datapath.
//   Accepts operand, count and mode over a valid/ready handshake, then steps one bit position per clock.
//   Adds arithmetic shift and rotate-through-carry modes, carry-in, a zero flag and flush, all in one unit.
//   Sits beside the combinational ALU; the control FSM issues long or variable shifts here.
// PARAMETERS
//   WIDTH  8  operand/result width in bits (>=2)
//   CNT_W  3  shift-count width; counts up to 2**CNT_W-1, may exceed WIDTH
// PORTS
//   clk        in   1       rising-edge clock, single clock domain
//   rst_n      in   1       asynchronous, active-low reset
//   flush      in   1       synchronous abort; returns unit to IDLE
//   in_valid   in   1       request valid
//   in_ready   out  1       unit can accept a request (state IDLE)
//   A          in   WIDTH   operand
//   Cnt        in   CNT_W   shift count
//   mode       in   3       000 SHL, 001 SHR, 010 SAR, 011 ROL, 100 ROR, 101 RCL, 110 RCR, 111 = SHL
//   ci         in   1       carry-in, used only by RCL/RCR
//   out_valid  out  1       result valid (state DONE)
//   out_ready  in   1       consumer takes result
//   S          out  WIDTH   result
//   Co         out  1       carry-out
//   Z          out  1       1 when S == 0
// BEHAVIOUR
//   Reset: state IDLE; S=0, Co=0, Z=0, out_valid=0, in_ready=1; internal count and mode regs cleared.
//   FSM states and transitions:
//     IDLE: in_ready=1. in_valid=1 latches A, Cnt, mode into internal regs and goes to SHIFT.
//       Carry register loads ci for RCL/RCR and 0 for all other modes.
//     SHIFT: while remaining>0, do one step per clock and decrement remaining.
//       When remaining==0, go to DONE.
//     DONE: out_valid=1. S, Co and Z stay stable until out_ready=1, then go to IDLE.
//   Latency: out_valid rises Cnt+1 clocks after the accept edge. Throughput is one request per Cnt+3 clocks.
//   Single step (n=WIDTH-1):
//     SHL: C<=S[n], S<={S[n-1:0],0}.
//     SHR: C<=S[0], S<={0,S[n:1]}.
//     SAR: C<=S[0], S<={S[n],S[n:1]}.
//     ROL: S<={S[n-1:0],S[n]}, C<=S[n] (new S[0]).
//     ROR: S<={S[0],S[n:1]}, C<=S[0] (new S[n]).
//     RCL: {C,S}<={S,C}.
//     RCR: {S,C}<={C,S}.
//   Cnt=0: S=A. Co=ci for RCL/RCR and 0 for all other modes.
//   Cnt>=WIDTH: no saturation or truncation; stepping gives the natural result.
//     SHL/SHR give 0. SAR gives all sign bits.
//     ROL/ROR wrap modulo WIDTH. RCL/RCR wrap modulo WIDTH+1.
//   Z is computed from the final S and registered together with it.
//   flush is sampled in every state and wins over all other inputs.
//     Next state is IDLE and out_valid drops; the result is discarded.
//     S, Co and Z keep their last value.
//   in_ready is 0 in SHIFT and DONE; in_valid in those states is ignored (no queueing).
//   DONE->IDLE costs one clock; a new request is not accepted in the same cycle as out_ready.
//   Reset asserted mid-operation aborts immediately to the reset values.
// TESTING
//   1. SHL, A=0xB4, Cnt=3 -> out_valid 4 clocks after accept; S=0xA0, Co=1, Z=0.
//   2. SAR, A=0x96, Cnt=2 -> S=0xE5, Co=1.
//      SHR with the same A and Cnt -> S=0x25, Co=1.
//   3. ROR, A=0x01, Cnt=1 -> S=0x80, Co=1.
//      ROL, A=0x81, Cnt=7 -> S=0xC0, Co=0.
//   4. RCL, A=0x80, ci=0, Cnt=1 -> S=0x00, Co=1, Z=1.
//      RCL, A=0x80, ci=0, Cnt=9 -> S=0x80, Co=0 (full ring).
//   5. Cnt=0, SHL, A=0x5A -> out_valid 1 clock after accept; S=0x5A, Co=0.
//      Hold out_ready=0 for 5 clocks -> S, Co, Z stable, in_ready=0.
//   6. Flush: SHL, Cnt=7, flush on the 3rd SHIFT clock -> IDLE next clock; out_valid never rises; next request works normally.
//      Async reset mid-SHIFT -> all outputs at reset values immediately.

Source files
------------

// File: rtl/alu_shift_seq_if.sv
// alu_shift_seq_if: request/result handshake bundle for the multi-cycle shift/rotate unit
// Request side : flush, in_valid, in_ready, A (operand), Cnt (step count), mode, ci (carry-in)
// Result side  : out_valid, out_ready, S (result), Co (carry-out), Z (S == 0)
// slave modport is the shift unit, master modport is the issuing controller.
interface alu_shift_seq_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [CNT_W-1:0] Cnt;
    logic [2:0]       mode;
    logic             ci;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             Co;
    logic             Z;
    modport slave (
        input  flush, in_valid, A, Cnt, mode, ci, out_ready,
        output in_ready, out_valid, S, Co, Z
    );
    modport master (
        output flush, in_valid, A, Cnt, mode, ci, out_ready,
        input  in_ready, out_valid, S, Co, Z
    );
endinterface

// File: rtl/alu_shift_seq.sv
// alu_shift_seq: multi-cycle shift/rotate unit stepping one bit position per clock
// Ports: clk (rising edge), rst_n (async, active low), bus (alu_shift_seq_if.slave):
//   request  flush, in_valid/in_ready, A, Cnt, mode, ci
//   result   out_valid/out_ready, S, Co, Z (held stable in DONE, kept across flush)
module alu_shift_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_shift_seq_if.slave    bus
);
    localparam logic [2:0] M_SHR = 3'b001;
    localparam logic [2:0] M_SAR = 3'b010;
    localparam logic [2:0] M_ROL = 3'b011;
    localparam logic [2:0] M_ROR = 3'b100;
    localparam logic [2:0] M_RCL = 3'b101;
    localparam logic [2:0] M_RCR = 3'b110;
    localparam logic [CNT_W-1:0] ONE = 1;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] s_q, s_d, res_q, res_d;
    logic             c_q, c_d, co_q, co_d, z_q, z_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [2:0]       mode_q, mode_d;
    logic             left, fill_l, fill_r, step_c;
    logic [WIDTH-1:0] step_s;
    // One step: left-moving modes take the carry from the MSB, right-moving ones from the LSB;
    // only the bit filled into the vacated position differs between modes.
    always_comb begin
        left   = !(mode_q inside {M_SHR, M_SAR, M_ROR, M_RCR});
        fill_l = mode_q == M_ROL ? s_q[WIDTH-1] : mode_q == M_RCL ? c_q : 1'b0;
        fill_r = mode_q == M_SAR ? s_q[WIDTH-1] : mode_q == M_ROR ? s_q[0] :
                 mode_q == M_RCR ? c_q : 1'b0;
        step_s = left ? {s_q[WIDTH-2:0], fill_l} : {fill_r, s_q[WIDTH-1:1]};
        step_c = left ? s_q[WIDTH-1] : s_q[0];
    end
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        c_d     = c_q;
        rem_d   = rem_q;
        mode_d  = mode_q;
        res_d   = res_q;
        co_d    = co_q;
        z_d     = z_q;
        if (bus.flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (bus.in_valid) begin
                    state_d = SHIFT;
                    s_d     = bus.A;
                    c_d     = (bus.mode == M_RCL || bus.mode == M_RCR) ? bus.ci : 1'b0;
                    rem_d   = bus.Cnt;
                    mode_d  = bus.mode;
                end
                SHIFT: if (rem_q != '0) begin
                    s_d   = step_s;
                    c_d   = step_c;
                    rem_d = rem_q - ONE;
                end else begin
                    // Result registers only update here, so a flush leaves the previous result visible.
                    state_d = DONE;
                    res_d   = s_q;
                    co_d    = c_q;
                    z_d     = s_q == '0;
                end
                DONE: if (bus.out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s_q     <= '0;
            c_q     <= 1'b0;
            rem_q   <= '0;
            mode_q  <= '0;
            res_q   <= '0;
            co_q    <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            c_q     <= c_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
            res_q   <= res_d;
            co_q    <= co_d;
            z_q     <= z_d;
        end
    end
    assign bus.in_ready  = state_q == IDLE;
    assign bus.out_valid = state_q == DONE;
    assign bus.S         = res_q;
    assign bus.Co        = co_q;
    assign bus.Z         = z_q;
endmodule

// File: tb/tb_alu_shift_seq.sv
// tb_alu_shift_seq: scoreboard bench for alu_shift_seq with random and directed requests
module tb_alu_shift_seq;
    localparam int W  = 8;
    localparam int CW = 4;
    typedef struct packed {
        logic [W-1:0] s;
        logic         co;
        logic         z;
    } res_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    res_t exp_q[$];
    res_t mon_e;
    always #5 clk = ~clk;
    alu_shift_seq_if #(.WIDTH(W), .CNT_W(CW)) bus ();
    alu_shift_seq #(.WIDTH(W), .CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask
    // Reference: whole-count shifts/rotations with plain operators on widened vectors.
    function automatic res_t model(input logic [W-1:0] a, input int cnt, input logic [2:0] mode,
                                   input logic ci);
        logic [31:0] w;
        logic [17:0] r;
        logic [8:0]  v;
        res_t        o;
        int          k;
        case (mode)
            3'd1: begin w = {16'h0, a, 8'h0} >> cnt; o.s = w[15:8]; o.co = w[7]; end
            3'd2: begin w = 32'($signed({a, 8'h0}) >>> cnt); o.s = w[15:8]; o.co = w[7]; end
            3'd3: begin
                k = cnt % W; w = {16'h0, a, a} << k; o.s = w[15:8]; o.co = (cnt == 0) ? 1'b0 : o.s[0];
            end
            3'd4: begin
                k = cnt % W; w = {16'h0, a, a} >> k; o.s = w[7:0]; o.co = (cnt == 0) ? 1'b0 : o.s[W-1];
            end
            3'd5: begin
                k = cnt % (W + 1); r = {ci, a, ci, a} << k; v = r[17:9]; o.s = v[7:0]; o.co = v[8];
            end
            3'd6: begin
                k = cnt % (W + 1); r = {ci, a, ci, a} >> k; v = r[8:0]; o.s = v[7:0]; o.co = v[8];
            end
            default: begin w = {24'h0, a} << cnt; o.s = w[7:0]; o.co = w[8]; end
        endcase
        o.z = o.s == 0;
        return o;
    endfunction
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("S", bus.S, mon_e.s);
                chk("Co", bus.Co, mon_e.co);
                chk("Z", bus.Z, mon_e.z);
            end
        end
    end
    // Presents a request at a negedge and returns 1 ns after the accept edge.
    task automatic issue(input logic [W-1:0] a, input int cnt, input logic [2:0] mode, input logic ci);
        int n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) chk("idle_timeout", 0, 1);
        @(negedge clk);
        bus.A = a;
        bus.Cnt = CW'(cnt);
        bus.mode = mode;
        bus.ci = ci;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask
    task automatic run(input logic [W-1:0] a, input int cnt, input logic [2:0] mode, input logic ci,
                       input int hold, input bit noise);
        res_t ex = model(a, cnt, mode, ci);
        int   lat = 0;
        exp_q.push_back(ex);
        issue(a, cnt, mode, ci);
        chk("in_ready_busy", bus.in_ready, 0);
        if (noise) begin
            bus.in_valid = 1'b1;
            bus.A = W'($urandom);
            bus.mode = 3'($urandom);
            bus.Cnt = CW'($urandom);
        end
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        bus.in_valid = 1'b0;
        chk("latency", lat, cnt + 1);
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #1;
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_in_ready", bus.in_ready, 0);
            chk("hold_S", bus.S, ex.s);
            chk("hold_Co", bus.Co, ex.co);
            chk("hold_Z", bus.Z, ex.z);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("idle_after_done", {bus.in_ready, bus.out_valid}, 2'b10);
    endtask
    initial begin
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.A = '0;
        bus.Cnt = '0;
        bus.mode = '0;
        bus.ci = 1'b0;
        bus.out_ready = 1'b0;
        #2;
        chk("reset_outputs", {bus.S, bus.Co, bus.Z, bus.out_valid, bus.in_ready}, {8'h00, 4'b0001});
        @(negedge clk);
        rst_n = 1'b1;
        run(8'hB4, 3, 3'd0, 1'b0, 0, 1'b0);
        run(8'h96, 2, 3'd2, 1'b0, 0, 1'b0);
        run(8'h96, 2, 3'd1, 1'b0, 0, 1'b0);
        run(8'h01, 1, 3'd4, 1'b0, 0, 1'b0);
        run(8'h81, 7, 3'd3, 1'b0, 0, 1'b0);
        run(8'h80, 1, 3'd5, 1'b0, 0, 1'b0);
        run(8'h80, 9, 3'd5, 1'b0, 0, 1'b0);
        run(8'h5A, 0, 3'd0, 1'b0, 5, 1'b0);
        run(8'h3C, 0, 3'd6, 1'b1, 1, 1'b0);
        run(8'hC3, 15, 3'd2, 1'b0, 0, 1'b0);
        run(8'hA5, 13, 3'd6, 1'b1, 0, 1'b1);
        run(8'hFF, 8, 3'd7, 1'b1, 0, 1'b0);
        for (int i = 0; i < 150; i++)
            run(W'($urandom), int'($urandom_range(0, 15)), 3'($urandom), 1'($urandom),
                int'($urandom_range(0, 3)), 1'($urandom));
        // Flush on the third SHIFT clock: result dropped, previous outputs retained.
        run(8'h21, 2, 3'd0, 1'b0, 0, 1'b0);
        issue(8'hFF, 7, 3'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        chk("flush_idle", {bus.in_ready, bus.out_valid}, 2'b10);
        chk("flush_keeps_S", bus.S, 8'h84);
        repeat (10) begin
            @(negedge clk);
            chk("flush_no_valid", bus.out_valid, 0);
        end
        run(8'h5A, 1, 3'd0, 1'b0, 0, 1'b0);
        // Asynchronous reset in the middle of a shift.
        issue(8'h77, 6, 3'd3, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_reset", {bus.S, bus.Co, bus.Z, bus.out_valid, bus.in_ready}, {8'h00, 4'b0001});
        @(negedge clk);
        rst_n = 1'b1;
        run(8'h0F, 4, 3'd4, 1'b0, 0, 1'b0);
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
